// File: rtl/flash_pkg.sv
// flash_pkg: shared constants and state types for the flash read arbiter.
// Holds the READ opcode, address byte count and FSM encodings.
package flash_pkg;

    localparam logic [7:0] FLASH_CMD_READ   = 8'h03;
    localparam int         FLASH_ADDR_BYTES = 3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_CMD  = ST_CMD,
        S_ADDR = ST_ADDR,
        S_DATA = ST_DATA,
        S_HOLD = ST_HOLD
    } fsm_t;

    typedef enum logic [1:0] {
        I_IDLE,
        I_START,
        I_WAIT
    } iss_t;

    // Address bytes go out MSB first: idx 0 -> [23:16].
    function automatic logic [7:0] addr_byte(input logic [23:0] a,
                                             input logic [1:0]  i);
        logic [7:0] b;
        case (i)
            2'd0:    b = a[23:16];
            2'd1:    b = a[15:8];
            default: b = a[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_issuer.sv
// spi_byte_issuer: one-byte start/busy handshake with the spi master.
// Ports: go/tx_byte in, spi_start/spi_din out, idle/byte_done/rx_byte back.
module spi_byte_issuer
    import flash_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [7:0] tx_byte,
    input  logic       spi_busy,
    input  logic [7:0] spi_dout,
    output logic       spi_start,
    output logic [7:0] spi_din,
    output logic       idle,
    output logic       byte_done,
    output logic [7:0] rx_byte
);

    iss_t       st, st_d;
    logic       start_d;
    logic [7:0] din_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= I_IDLE;
            spi_start <= 1'b0;
            spi_din   <= 8'h00;
        end else begin
            st        <= st_d;
            spi_start <= start_d;
            spi_din   <= din_d;
        end
    end

    always_comb begin
        st_d    = st;
        start_d = spi_start;
        din_d   = spi_din;
        unique case (st)
            I_IDLE: if (go) begin
                start_d = 1'b1;
                din_d   = tx_byte;
                st_d    = I_START;
            end
            I_START: if (spi_busy) begin
                start_d = 1'b0;
                st_d    = I_WAIT;
            end
            I_WAIT: if (!spi_busy) st_d = I_IDLE;
            default: st_d = I_IDLE;
        endcase
    end

    // Completion is flagged in the cycle busy is seen low; the top
    // registers it, so rd_valid lands one cycle after the fall.
    assign idle      = (st == I_IDLE);
    assign byte_done = (st == I_WAIT) && !spi_busy;
    assign rx_byte   = spi_dout;

endmodule

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin sharing of the SPI flash between two readers.
// Ports: req/addr/len/pause per reader, gnt/rd_*/done/busy back, spi_* and cs to flash.
module flash_read_arbiter
    import flash_pkg::*;
#(
    parameter int CS_IDLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [1:0]  req,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [15:0] len0,
    input  logic [15:0] len1,
    input  logic [1:0]  pause,
    output logic [1:0]  gnt,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [1:0]  done,
    output logic        busy,
    output logic        spi_start,
    output logic [7:0]  spi_din,
    input  logic        spi_busy,
    input  logic [7:0]  spi_dout,
    output logic        cs
);

    fsm_t        state, state_d;
    logic [1:0]  gnt_d, done_d, idx, idx_d;
    logic [7:0]  rd_data_d, tx_byte, rx_byte;
    logic        rd_valid_d, busy_d, cs_d, last, last_d;
    logic        abort_q, abort_d, go, iss_idle, iss_done;
    logic [15:0] rem, rem_d, len_sel;
    logic [23:0] addr_q, addr_d;
    logic [3:0]  hold_cnt, hold_d;
    logic        win1, gsel, req_g, pause_g, aborting;

    spi_byte_issuer u_iss (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .tx_byte   (tx_byte),
        .spi_busy  (spi_busy),
        .spi_dout  (spi_dout),
        .spi_start (spi_start),
        .spi_din   (spi_din),
        .idle      (iss_idle),
        .byte_done (iss_done),
        .rx_byte   (rx_byte)
    );

    // last=1 means requester 1 was served last, so 0 wins a tie.
    assign win1     = req[1] && (!req[0] || !last);
    assign len_sel  = win1 ? len1 : len0;
    assign gsel     = gnt[1];
    assign req_g    = req[gsel];
    assign pause_g  = pause[gsel];
    assign aborting = abort_q || !req_g;
    assign tx_byte  = (state == S_CMD)  ? FLASH_CMD_READ :
                      (state == S_ADDR) ? addr_byte(addr_q, idx) : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            gnt      <= 2'b00;
            done     <= 2'b00;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            cs       <= 1'b1;
            last     <= 1'b1;
            abort_q  <= 1'b0;
            rem      <= 16'h0;
            addr_q   <= 24'h0;
            idx      <= 2'd0;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_d;
            gnt      <= gnt_d;
            done     <= done_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_valid_d;
            busy     <= busy_d;
            cs       <= cs_d;
            last     <= last_d;
            abort_q  <= abort_d;
            rem      <= rem_d;
            addr_q   <= addr_d;
            idx      <= idx_d;
            hold_cnt <= hold_d;
        end
    end

    always_comb begin
        state_d    = state;
        gnt_d      = gnt;
        done_d     = 2'b00;
        rd_data_d  = rd_data;
        rd_valid_d = 1'b0;
        busy_d     = busy;
        cs_d       = cs;
        last_d     = last;
        abort_d    = abort_q;
        rem_d      = rem;
        addr_d     = addr_q;
        idx_d      = idx;
        hold_d     = hold_cnt;
        go         = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ready && !spi_busy && req != 2'b00) begin
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    addr_d  = win1 ? addr1 : addr0;
                    rem_d   = len_sel;
                    abort_d = 1'b0;
                    idx_d   = 2'd0;
                    hold_d  = 4'd0;
                    if (len_sel == 16'h0) begin
                        done_d  = gnt_d;
                        state_d = S_HOLD;
                    end else begin
                        cs_d    = 1'b0;
                        state_d = S_CMD;
                    end
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                if (!req_g) abort_d = 1'b1;
                if (iss_done) begin
                    if (aborting) begin
                        cs_d    = 1'b1;
                        hold_d  = 4'd0;
                        state_d = S_HOLD;
                    end else if (state == S_CMD) begin
                        state_d = S_ADDR;
                    end else if (state == S_ADDR) begin
                        if (idx == 2'(FLASH_ADDR_BYTES - 1)) state_d = S_DATA;
                        else idx_d = idx + 2'd1;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = rx_byte;
                        rem_d      = rem - 16'd1;
                        if (rem == 16'd1) begin
                            done_d  = gnt;
                            cs_d    = 1'b1;
                            hold_d  = 4'd0;
                            state_d = S_HOLD;
                        end
                    end
                end else if (iss_idle) begin
                    if (aborting) begin
                        cs_d    = 1'b1;
                        hold_d  = 4'd0;
                        state_d = S_HOLD;
                    end else if (!(state == S_DATA && pause_g)) begin
                        go = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (hold_cnt == 4'(CS_IDLE_CYCLES - 1)) begin
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    last_d  = gnt[1];
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_cnt + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: directed bench with a behavioural spi/flash model.
// Covers single read, contention, pause, len=0, abort, ready gating and reset.
module tb_flash_read_arbiter;

    localparam int BYTE_T = 4;

    logic        clk, rst, ready, spi_busy, spi_start, rd_valid, busy, cs;
    logic [1:0]  req, pause, gnt, done;
    logic [23:0] addr0, addr1;
    logic [15:0] len0, len1;
    logic [7:0]  rd_data, spi_din, spi_dout;

    int n_run, n_fail;

    flash_read_arbiter #(.CS_IDLE_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .len0      (len0),
        .len1      (len1),
        .pause     (pause),
        .gnt       (gnt),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .busy      (busy),
        .spi_start (spi_start),
        .spi_din   (spi_din),
        .spi_busy  (spi_busy),
        .spi_dout  (spi_dout),
        .cs        (cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model and monitor state
    logic [7:0] mosi_q[$];
    logic [7:0] rd_q[$];
    int         gnt_log[$];
    int         cnt, kidx, kcur;
    logic [7:0] base;
    int done0, done1, done_w_valid, done_cs_low, cs_bad, overlap_bad;
    int hi_run, min_gap, seen_fall, start_in_pause, cs_hi_pause;
    logic prev_cs;
    logic [1:0] prev_gnt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        mosi_q.delete();
        rd_q.delete();
        gnt_log.delete();
        done0 = 0; done1 = 0; done_w_valid = 0; done_cs_low = 0;
        cs_bad = 0; overlap_bad = 0; seen_fall = 0; min_gap = 99;
        start_in_pause = 0; cs_hi_pause = 0;
    endtask

    // One negedge: observe DUT outputs, then advance the spi model.
    task automatic step();
        @(negedge clk);
        if (rd_valid) rd_q.push_back(rd_data);
        if (done[0]) done0++;
        if (done[1]) done1++;
        if (done != 2'b00 && rd_valid) done_w_valid++;
        if (done != 2'b00 && !cs) done_cs_low++;
        if (!cs && gnt == 2'b00) cs_bad++;
        if (spi_start && spi_busy) overlap_bad++;
        if (gnt != 2'b00 && prev_gnt == 2'b00) gnt_log.push_back(int'(gnt[1]));
        if (pause[0] && spi_start) start_in_pause++;
        if (pause[0] && cs) cs_hi_pause++;
        if (cs) hi_run++;
        if (prev_cs && !cs) begin
            if (seen_fall != 0 && hi_run < min_gap) min_gap = hi_run;
            seen_fall = 1;
            hi_run = 0;
        end
        prev_cs = cs;
        prev_gnt = gnt;
        if (cs) kidx = 0;
        if (!rst) begin
            spi_busy = 1'b0;
            cnt = 0;
        end else if (spi_busy) begin
            cnt--;
            if (cnt == 0) begin
                spi_busy = 1'b0;
                spi_dout = (kcur >= 4) ? base + 8'(kcur - 4) : 8'hFF;
            end
        end else if (spi_start) begin
            mosi_q.push_back(spi_din);
            kcur = kidx;
            kidx++;
            spi_busy = 1'b1;
            cnt = BYTE_T;
        end
    endtask

    task automatic settle();
        int b = 0;
        while ((busy || gnt != 2'b00) && b < 200) begin step(); b++; end
        chk("settle_timeout", 32'(b < 200), 1);
        repeat (3) step();
    endtask

    logic [7:0] exp_mosi [8];

    initial begin
        int b;
        n_run = 0; n_fail = 0;
        rst = 1'b0; ready = 1'b0; req = 2'b00; pause = 2'b00;
        addr0 = 24'h0; addr1 = 24'h0; len0 = 16'h0; len1 = 16'h0;
        spi_busy = 1'b0; spi_dout = 8'h00; base = 8'h00;
        cnt = 0; kidx = 0; kcur = 0; hi_run = 0;
        prev_cs = 1'b1; prev_gnt = 2'b00;
        clear_mon();
        repeat (3) step();
        chk("rst_cs", 32'(cs), 1);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(spi_start), 0);
        chk("rst_din", 32'(spi_din), 0);
        chk("rst_rd", {23'h0, rd_valid, rd_data}, 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b1;
        ready = 1'b1;
        repeat (2) step();

        // single read
        clear_mon();
        addr0 = 24'h012345; len0 = 16'd4; base = 8'hA0;
        req = 2'b01;
        step();
        chk("t1_gnt_n1", 32'(gnt), 1);
        chk("t1_cs_n1", 32'(cs), 0);
        chk("t1_busy_n1", 32'(busy), 1);
        chk("t1_start_n1", 32'(spi_start), 0);
        step();
        chk("t1_start_n2", 32'(spi_start), 1);
        b = 0;
        while (done0 == 0 && b < 500) begin step(); b++; end
        chk("t1_done_timeout", 32'(b < 500), 1);
        req = 2'b00;
        settle();
        exp_mosi = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
        chk("t1_mosi_n", mosi_q.size(), 8);
        for (int i = 0; i < 8 && i < mosi_q.size(); i++)
            chk($sformatf("t1_mosi%0d", i), 32'(mosi_q[i]), 32'(exp_mosi[i]));
        chk("t1_rd_n", rd_q.size(), 4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++)
            chk($sformatf("t1_rd%0d", i), 32'(rd_q[i]), 32'(8'hA0 + i));
        chk("t1_done_cnt", done0, 1);
        chk("t1_done_w_valid", done_w_valid, 1);
        chk("t1_done_cs", done_cs_low, 0);
        chk("t1_cs_outside", cs_bad, 0);

        // len1 = 0
        clear_mon();
        len1 = 16'd0; req = 2'b10;
        step();
        chk("t4_gnt", 32'(gnt), 2);
        chk("t4_done", 32'(done), 2);
        chk("t4_cs", 32'(cs), 1);
        req = 2'b00;
        settle();
        chk("t4_done1_cnt", done1, 1);
        chk("t4_no_cs", seen_fall, 0);
        chk("t4_no_bytes", mosi_q.size(), 0);

        // contention
        clear_mon();
        len0 = 16'd2; len1 = 16'd2; addr1 = 24'hABCDEF; base = 8'h10;
        req = 2'b11;
        b = 0;
        while (done0 + done1 < 4 && b < 2000) begin step(); b++; end
        chk("t2_timeout", 32'(b < 2000), 1);
        req = 2'b00;
        settle();
        chk("t2_grants", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            chk($sformatf("t2_gnt%0d", i), gnt_log[i], i % 2);
        chk("t2_gap_ge2", 32'(min_gap >= 2 && min_gap != 99), 1);
        chk("t2_overlap", overlap_bad, 0);
        chk("t2_rd_n", rd_q.size(), 8);
        chk("t2_mosi_n", mosi_q.size(), 24);

        // pause
        clear_mon();
        len0 = 16'd8; base = 8'h40; req = 2'b01;
        b = 0;
        while (rd_q.size() < 2 && b < 500) begin step(); b++; end
        chk("t3_wait2", 32'(b < 500), 1);
        pause = 2'b01;
        repeat (20) step();
        pause = 2'b00;
        b = 0;
        while (done0 == 0 && b < 1000) begin step(); b++; end
        chk("t3_done_timeout", 32'(b < 1000), 1);
        req = 2'b00;
        settle();
        chk("t3_no_start", start_in_pause, 0);
        chk("t3_cs_low", cs_hi_pause, 0);
        chk("t3_rd_n", rd_q.size(), 8);
        if (rd_q.size() == 8) chk("t3_last", 32'(rd_q[7]), 32'h47);

        // abort after 3 of 10
        clear_mon();
        len0 = 16'd10; base = 8'h60; req = 2'b01;
        b = 0;
        while (rd_q.size() < 3 && b < 500) begin step(); b++; end
        chk("t5_wait3", 32'(b < 500), 1);
        req = 2'b00;
        repeat (30) step();
        chk("t5_rd_n", rd_q.size(), 3);
        chk("t5_no_done", done0, 0);
        chk("t5_cs", 32'(cs), 1);
        chk("t5_gnt", 32'(gnt), 0);
        chk("t5_busy", 32'(busy), 0);

        // ready gating and async reset
        clear_mon();
        ready = 1'b0; len0 = 16'd1; req = 2'b01;
        b = 0;
        repeat (100) begin
            step();
            if (gnt != 2'b00) b++;
        end
        chk("t6_no_gnt", b, 0);
        ready = 1'b1;
        step();
        chk("t6_gnt", 32'(gnt), 1);
        b = 0;
        while (mosi_q.size() < 5 && b < 500) begin step(); b++; end
        chk("t6_wait_data", 32'(b < 500), 1);
        step();
        chk("t6_pre_cs", 32'(cs), 0);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_cs", 32'(cs), 1);
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_start", 32'(spi_start), 0);
        req = 2'b00;
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("t6_post_rd", 32'(rd_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_read_arbiter.md
# flash_read_arbiter

Shares the single SPI master and the serial flash chip-select between two read requesters, for example the NES PRG/CHR loader and the UART debug dumper. It arbitrates round-robin and issues the flash READ (0x03) command plus a 24-bit address, then streams the requested byte count back to the winner. It sits between the requesters and the `spi` instance, drives `cs` directly, and holds off all flash traffic until the AVR reports `ready`.

## Interface
- `CS_IDLE_CYCLES`, default 2: minimum cycles `cs` stays high between transactions (range 1..15).
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-low reset.
- `ready` input 1: AVR ready. No transaction starts while it is low.
- `req[1:0]` input 2: per-requester read request, level-sensitive.
- `addr0`, `addr1` input 24 each: flash start address, sampled at grant.
- `len0`, `len1` input 16 each: byte count, sampled at grant.
- `pause[1:0]` input 2: per-requester stall. The granted requester's bit blocks the next SPI byte.
- `gnt[1:0]` output 2: one-hot grant, held for the whole transaction.
- `rd_data` output 8: read byte.
- `rd_valid` output 1: one-cycle strobe. Belongs to the requester in `gnt`.
- `done[1:0]` output 2: one-cycle completion strobe per requester.
- `busy` output 1: high from grant until the end of `CS_HOLD`.
- `spi_start` output 1: start request to the `spi` master.
- `spi_din` output 8: byte to shift out.
- `spi_busy` input 1: `spi` busy flag.
- `spi_dout` input 8: byte shifted in. Valid when `spi_busy` falls.
- `cs` output 1: flash chip-select, active-low.

## Operation
- Every output is registered.
- Reset values: `cs`=1, `spi_start`=0, `spi_din`=0, `gnt`=0, `rd_data`=0, `rd_valid`=0, `done`=0, `busy`=0.
- Reset takes effect immediately and aborts any transfer; `cs` rises asynchronously.
- **States:** IDLE, CMD, ADDR, DATA, CS_HOLD.
- **IDLE:**
  - Arbitration runs when `ready`=1, `spi_busy`=0 and `req`≠0.
  - If only one requester is asking, it wins. If both are asking, the one not granted last wins. `last` resets so that requester 0 wins the first tie.
  - On a win: latch addr/len, set `gnt`, set `busy`.
  - If len≠0: drop `cs` and go to CMD.
  - If len=0: pulse `done` next cycle, go to CS_HOLD, `cs` never falls.
- **Byte issue (shared by CMD, ADDR and DATA):**
  - Drive `spi_din` and hold `spi_start`=1 until `spi_busy`=1 is seen.
  - Deassert `spi_start` in the cycle after `spi_busy` is seen high.
  - Wait for `spi_busy`=0, then move on.
- **CMD:** send 0x03.
- **ADDR:** send addr[23:16], then [15:8], then [7:0], using a 2-bit byte counter.
- **DATA:** send 0x00.
  - On each completed byte: `rd_data`=`spi_dout`, pulse `rd_valid`, decrement the remaining count.
  - Do not issue a new byte while `pause[g]`=1. `cs` stays low during a pause.
  - When the count reaches 0: pulse `done[g]` together with the last `rd_valid`, raise `cs`, go to CS_HOLD.
- **Abort:** if `req[g]` drops during CMD, ADDR or DATA:
  - Finish the in-flight SPI byte and discard it (no `rd_valid`).
  - Raise `cs`, go to CS_HOLD, no `done`.
- **CS_HOLD:** count `CS_IDLE_CYCLES`, then clear `gnt` and `busy`, update `last`, return to IDLE.
- **Widths:**
  - The remaining count is 16-bit and never underflows, because len=0 is handled in IDLE.
  - The address is not incremented by the controller; the flash auto-increments and wraps at its own boundary.
- `ready` falling mid-transaction has no effect; it only gates IDLE.

## Timing
- Request seen in IDLE at cycle N: `gnt`, `busy` and `cs`=0 at N+1; `spi_start`=1 at N+2.
- Overhead per transaction: 4 SPI bytes (command + 3 address bytes) before the first data byte.
- `rd_valid` rises 1 cycle after the `spi_busy` falling edge.
- Minimum gap between consecutive data bytes: SPI byte time + 3 cycles.
- `done` falls 1 cycle after it rises. `gnt` clears `CS_IDLE_CYCLES` cycles after `cs` rises.
- Next grant is possible no earlier than 1 cycle after `gnt` clears.

## Structure
- Shared package `flash_pkg`:
  - state encoding localparams;
  - `FLASH_CMD_READ`=8'h03;
  - `FLASH_ADDR_BYTES`=3.
- One natural sub-module, `spi_byte_issuer`: the start/busy handshake plus capture, reused by all three byte states. Everything else stays in the top FSM.

## Test plan
- **Single read:** req0, addr0=0x012345, len0=4, spi model returns 0xA0..0xA3. Required:
  - MOSI bytes 03 01 23 45 00 00 00 00;
  - four `rd_valid` with A0..A3;
  - `done[0]` coincident with A3;
  - `cs` low only between `gnt` and `done`.
- **Contention:** req0 and req1 both held with len=2, repeated. Required:
  - grants alternate 0,1,0,1;
  - `cs` high ≥2 cycles between transactions;
  - no byte overlap.
- **Pause:** assert `pause[0]` for 20 cycles after the second of 8 bytes. Required:
  - no `spi_start` during the pause;
  - `cs` stays low;
  - exactly 8 `rd_valid` in total.
- **len=0 and abort:**
  - len1=0: `done[1]` pulses with no `cs` activity.
  - Separately, drop req0 after 3 of 10 bytes: no further `rd_valid`, no `done[0]`, `cs` returns high.
- **Ready and reset:**
  - With `ready`=0, req held for 100 cycles: no grant. Raise `ready`: grant next cycle.
  - Assert `rst` low mid-DATA: `cs`=1, `gnt`=0, `spi_start`=0 immediately.
